// File: rtl/mem_pkg.sv
// Shared constants and address-decode helpers for the four-bank main memory
// and the cache controller that feeds it.
package mem_pkg;

  localparam int NUM_BANKS  = 4;
  localparam int BANK_LAT   = 4;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  // Word offsets within a 4-word line, matching the controller's mem_offset.
  localparam logic [2:0] MEM_OFF_0 = 3'd0;
  localparam logic [2:0] MEM_OFF_1 = 3'd2;
  localparam logic [2:0] MEM_OFF_2 = 3'd4;
  localparam logic [2:0] MEM_OFF_3 = 3'd6;

  function automatic logic [1:0] bank_sel(input logic [2:0] addr_lo);
    return addr_lo[2:1];
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 3;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One word-wide memory bank: storage, occupancy down-counter and a registered
// read port that captures the word at the accept edge.
module mem_bank
  import mem_pkg::*;
#(
  parameter int IDX_W    = 13,
  parameter int DATA_W   = mem_pkg::MEM_DATA_W,
  parameter int BANK_LAT = mem_pkg::BANK_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    cnt_d = cnt_q;
    if (acc)
      cnt_d = 4'(BANK_LAT - 1);
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= 4'd0;
    else
      cnt_q <= cnt_d;
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (acc) begin
      if (we)
        mem[idx] <= wdata;
      else
        rdata_q <= mem[idx];
    end
  end

  assign busy  = (cnt_q != 4'd0);
  assign rdata = rdata_q;

endmodule

// File: rtl/four_bank_mem_sched.sv
// Four-bank interleaved main memory: decodes requests, stalls only on bank
// conflict, and returns read data through a fixed two-stage pipeline.
module four_bank_mem_sched
  import mem_pkg::*;
#(
  parameter int ADDR_W   = mem_pkg::MEM_ADDR_W,
  parameter int DATA_W   = mem_pkg::MEM_DATA_W,
  parameter int BANK_LAT = mem_pkg::BANK_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int IDX_W = ADDR_W - 3;

  // Handshake: a request is held while stall=1 and is taken at the edge
  // ending the first cycle in which it is legal and stall=0.
  logic [1:0]       bank;
  logic [IDX_W-1:0] idx;
  logic             legal, acc_any;
  logic [3:0]       acc_vec, busy_w;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

  logic              v1_q, v1_d;
  logic [1:0]        bid1_q, bid1_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  always_comb begin
    bank    = bank_sel(addr[2:0]);
    idx     = IDX_W'(word_index(32'(addr)));
    legal   = (rd ^ wr) & ~addr[0];
    err     = (rd & wr) | ((rd | wr) & addr[0]);
    stall   = legal & busy_w[bank];
    acc_any = legal & ~busy_w[bank];
    acc_vec = acc_any ? (4'b0001 << bank) : 4'b0000;

    v1_d       = acc_any & rd;
    bid1_d     = acc_any ? bank : bid1_q;
    rd_valid_d = v1_q;
    data_out_d = v1_q ? bank_rdata[bid1_q] : data_out_q;
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    mem_bank #(
      .IDX_W    (IDX_W),
      .DATA_W   (DATA_W),
      .BANK_LAT (BANK_LAT)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .acc   (acc_vec[i]),
      .we    (wr),
      .idx   (idx),
      .wdata (data_in),
      .busy  (busy_w[i]),
      .rdata (bank_rdata[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      bid1_q     <= 2'd0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      v1_q       <= v1_d;
      bid1_q     <= bid1_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy     = busy_w;
  assign rd_valid = rd_valid_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_four_bank_mem_sched.sv
// Directed bench for four_bank_mem_sched: line streaming, conflicts, illegal
// requests, async reset, plus a BANK_LAT=2 instance.
module tb_four_bank_mem_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0] addr, data_in, data_out;
  logic        rd, wr, rd_valid, stall, err;
  logic [3:0]  busy;

  logic [15:0] addr2, data_in2, data_out2;
  logic        rd2, wr2, rd_valid2, stall2, err2;
  logic [3:0]  busy2;

  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  four_bank_mem_sched dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .rd_valid(rd_valid), .stall(stall), .busy(busy), .err(err)
  );

  four_bank_mem_sched #(.BANK_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .addr(addr2), .data_in(data_in2), .rd(rd2), .wr(wr2),
    .data_out(data_out2), .rd_valid(rd_valid2), .stall(stall2), .busy(busy2), .err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; data_in = d;
  endtask

  task automatic req2(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd2 = r; wr2 = w; addr2 = a; data_in2 = d;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    req2(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    next_cycle();

    // Stream a full line of writes: no stalls, banks fill in one per cycle.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) req(1'b0, 1'b1, 16'(16'h0040 + 2 * i), 16'(16'h1111 * (i + 1)));
      else idle();
      @(negedge clk);
      check($sformatf("wr_stream_stall_%0d", i), 32'(stall), 32'h0);
      case (i)
        0: check("wr_busy_0", 32'(busy), 32'h0);
        1: check("wr_busy_1", 32'(busy), 32'h1);
        2: check("wr_busy_2", 32'(busy), 32'h3);
        3: check("wr_busy_3", 32'(busy), 32'h7);
        default: check("wr_busy_4", 32'(busy), 32'he);
      endcase
      next_cycle();
    end
    idle_cycles(4);

    // Stream the line back; rd_valid on cycles 2..5 in order.
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) req(1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'h0000);
      else idle();
      @(negedge clk);
      check($sformatf("rd_stream_stall_%0d", i), 32'(stall), 32'h0);
      check($sformatf("rd_stream_valid_%0d", i), 32'(rd_valid), 32'((i >= 2) && (i <= 5)));
      if (rd_valid) begin
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check($sformatf("rd_stream_data_%0d", i), 32'(data_out), 32'(exp_v));
        end else begin
          check("rd_stream_extra", 32'(rd_valid), 32'h0);
        end
      end
      next_cycle();
    end
    check("rd_stream_drained", 32'(exp_q.size()), 32'h0);
    check("rd_hold_data", 32'(data_out), 32'h4444);

    // Same-bank conflict: write 0x40, then read 0x48 waits out the bank.
    req(1'b0, 1'b1, 16'h0048, 16'h5555);
    next_cycle();
    idle_cycles(4);
    req(1'b0, 1'b1, 16'h0040, 16'haaaa);
    next_cycle();
    req(1'b1, 1'b0, 16'h0048, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("conflict_stall_N+%0d", i), 32'(stall), 32'(i < 4));
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("conflict_valid_N+5", 32'(rd_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("conflict_valid_N+6", 32'(rd_valid), 32'h1);
    check("conflict_data_N+6", 32'(data_out), 32'h5555);
    next_cycle();
    idle_cycles(3);

    // Illegal requests: flagged, never accepted.
    req(1'b1, 1'b1, 16'h0010, 16'hdead);
    @(negedge clk);
    check("illegal_rdwr_err", 32'(err), 32'h1);
    check("illegal_rdwr_stall", 32'(stall), 32'h0);
    check("illegal_rdwr_busy", 32'(busy), 32'h0);
    next_cycle();
    req(1'b1, 1'b0, 16'h0011, 16'h0000);
    @(negedge clk);
    check("illegal_odd_err", 32'(err), 32'h1);
    check("illegal_odd_stall", 32'(stall), 32'h0);
    check("illegal_odd_busy", 32'(busy), 32'h0);
    next_cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("illegal_no_valid_%0d", i), 32'(rd_valid), 32'h0);
      check($sformatf("illegal_no_busy_%0d", i), 32'(busy), 32'h0);
      next_cycle();
    end

    // Async reset while a read is in flight drops it; memory survives.
    req(1'b1, 1'b0, 16'h0042, 16'h0000);
    next_cycle();
    idle();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_valid", 32'(rd_valid), 32'h0);
    #1 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_after_valid_%0d", i), 32'(rd_valid), 32'h0);
      check($sformatf("rst_after_busy_%0d", i), 32'(busy), 32'h0);
      next_cycle();
    end
    req(1'b1, 1'b0, 16'h0042, 16'h0000);
    next_cycle();
    idle_cycles(1);
    @(negedge clk);
    check("rst_reread_valid", 32'(rd_valid), 32'h1);
    check("rst_reread_data", 32'(data_out), 32'h2222);
    next_cycle();

    // BANK_LAT=2 instance: write then same-bank read costs one stall.
    req2(1'b0, 1'b1, 16'h0048, 16'h7777);
    next_cycle();
    idle_cycles(2);
    req2(1'b0, 1'b1, 16'h0040, 16'hbbbb);
    next_cycle();
    req2(1'b1, 1'b0, 16'h0048, 16'h0000);
    @(negedge clk);
    check("lat2_stall_M+1", 32'(stall2), 32'h1);
    next_cycle();
    @(negedge clk);
    check("lat2_stall_M+2", 32'(stall2), 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("lat2_valid_M+3", 32'(rd_valid2), 32'h0);
    next_cycle();
    @(negedge clk);
    check("lat2_valid_M+4", 32'(rd_valid2), 32'h1);
    check("lat2_data_M+4", 32'(data_out2), 32'h7777);
    next_cycle();
    req2(1'b1, 1'b0, 16'h0040, 16'h0000);
    next_cycle();
    idle_cycles(1);
    @(negedge clk);
    check("lat2_readback_data", 32'(data_out2), 32'hbbbb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
